// File: rtl/verlet_integration_engine.sv
// Multi-particle Verlet integrator: one integration step per particle on each start pulse.
module verlet_integration_engine #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      N_POINTS    = 16,
  parameter int unsigned      ADDR_W      = 4,
  parameter logic [WIDTH-1:0] GRAVITY     = WIDTH'(32'h00000333),
  parameter logic [WIDTH-1:0] DISTANCE    = WIDTH'(32'h000A0000),
  parameter int unsigned      MOUSE_SHIFT = 3,
  parameter logic [WIDTH-1:0] X_MAX       = WIDTH'(32'h01400000),
  parameter logic [WIDTH-1:0] Y_MAX       = WIDTH'(32'h00F00000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_x,
  input  logic [WIDTH-1:0]  load_y,
  input  logic              load_pin,
  input  logic              start,
  input  logic              mouse_en,
  input  logic [WIDTH-1:0]  mouse_x,
  input  logic [WIDTH-1:0]  mouse_y,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_x,
  output logic [WIDTH-1:0]  rd_y
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CALC, S_WRITE, S_DONE} state_t;

  // particle storage, deliberately left out of reset
  logic [WIDTH-1:0] cur_x_q  [N_POINTS];
  logic [WIDTH-1:0] cur_y_q  [N_POINTS];
  logic [WIDTH-1:0] prev_x_q [N_POINTS];
  logic [WIDTH-1:0] prev_y_q [N_POINTS];
  logic             pin_q    [N_POINTS];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]  rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic              mouse_en_q, mouse_en_d;
  logic [WIDTH-1:0]  mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [WIDTH-1:0]  f_x_q, f_x_d, f_y_q, f_y_d, f_px_q, f_px_d, f_py_q, f_py_d;
  logic              f_pin_q, f_pin_d;
  logic [WIDTH-1:0]  r_x_q, r_x_d, r_y_q, r_y_d, r_px_q, r_px_d, r_py_q, r_py_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_cx, mem_cy, mem_px, mem_py;
  logic              mem_pin;

  logic [WIDTH-1:0]  step_x, step_y, step_px, step_py;
  logic signed [WIDTH-1:0] dx, dy, adx, ady, pull_x, pull_y, sx, sy;
  logic              mouse_hit;

  // one Verlet step on the fetched particle: gravity, mouse pull, clamp, pinning
  always_comb begin
    dx        = $signed(f_x_q - mouse_x_q);
    dy        = $signed(f_y_q - mouse_y_q);
    adx       = dx[WIDTH-1] ? -dx : dx;
    ady       = dy[WIDTH-1] ? -dy : dy;
    mouse_hit = mouse_en_q && (adx < $signed(DISTANCE)) && (ady < $signed(DISTANCE));
    pull_x    = $signed(mouse_x_q - f_x_q) >>> MOUSE_SHIFT;
    pull_y    = $signed(mouse_y_q - f_y_q) >>> MOUSE_SHIFT;
    sx        = $signed((f_x_q << 1) - f_px_q);
    sy        = $signed((f_y_q << 1) - f_py_q + GRAVITY);
    if (mouse_hit) begin
      sx = sx + pull_x;
      sy = sy + pull_y;
    end
    step_x  = WIDTH'(sx);
    step_px = f_x_q;
    if (sx[WIDTH-1]) begin
      step_x  = '0;
      step_px = '0;
    end else if (sx > $signed(X_MAX)) begin
      step_x  = X_MAX;
      step_px = X_MAX;
    end
    step_y  = WIDTH'(sy);
    step_py = f_y_q;
    if (sy[WIDTH-1]) begin
      step_y  = '0;
      step_py = '0;
    end else if (sy > $signed(Y_MAX)) begin
      step_y  = Y_MAX;
      step_py = Y_MAX;
    end
    if (f_pin_q) begin
      step_x  = f_x_q;
      step_y  = f_y_q;
      step_px = f_px_q;
      step_py = f_py_q;
    end
  end

  // next-state, pipeline registers, storage write port and read port
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mouse_en_d = mouse_en_q;
    mouse_x_d  = mouse_x_q;
    mouse_y_d  = mouse_y_q;
    f_x_d      = f_x_q;
    f_y_d      = f_y_q;
    f_px_d     = f_px_q;
    f_py_d     = f_py_q;
    f_pin_d    = f_pin_q;
    r_x_d      = r_x_q;
    r_y_d      = r_y_q;
    r_px_d     = r_px_q;
    r_py_d     = r_py_q;
    mem_we     = 1'b0;
    mem_addr   = idx_q;
    mem_cx     = r_x_q;
    mem_cy     = r_y_q;
    mem_px     = r_px_q;
    mem_py     = r_py_q;
    mem_pin    = f_pin_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_valid && (32'(load_addr) < N_POINTS)) begin
          mem_we   = 1'b1;
          mem_addr = load_addr;
          mem_cx   = load_x;
          mem_cy   = load_y;
          mem_px   = load_x;
          mem_py   = load_y;
          mem_pin  = load_pin;
        end
        if (start) begin
          mouse_en_d = mouse_en;
          mouse_x_d  = mouse_x;
          mouse_y_d  = mouse_y;
          idx_d      = '0;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        f_x_d   = cur_x_q[idx_q];
        f_y_d   = cur_y_q[idx_q];
        f_px_d  = prev_x_q[idx_q];
        f_py_d  = prev_y_q[idx_q];
        f_pin_d = pin_q[idx_q];
        state_d = S_CALC;
      end
      S_CALC: begin
        r_x_d   = step_x;
        r_y_d   = step_y;
        r_px_d  = step_px;
        r_py_d  = step_py;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_READ) || (state_d == S_CALC) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    rd_x_d = '0;
    rd_y_d = '0;
    if (32'(rd_addr) < N_POINTS) begin
      rd_x_d = cur_x_q[rd_addr];
      rd_y_d = cur_y_q[rd_addr];
    end
  end

  // control state and outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
    end
  end

  // datapath pipeline registers, no reset needed
  always_ff @(posedge clk) begin
    mouse_en_q <= mouse_en_d;
    mouse_x_q  <= mouse_x_d;
    mouse_y_q  <= mouse_y_d;
    f_x_q      <= f_x_d;
    f_y_q      <= f_y_d;
    f_px_q     <= f_px_d;
    f_py_q     <= f_py_d;
    f_pin_q    <= f_pin_d;
    r_x_q      <= r_x_d;
    r_y_q      <= r_y_d;
    r_px_q     <= r_px_d;
    r_py_q     <= r_py_d;
  end

  // storage write; a reset edge suppresses the write in flight
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      cur_x_q[mem_addr]  <= mem_cx;
      cur_y_q[mem_addr]  <= mem_cy;
      prev_x_q[mem_addr] <= mem_px;
      prev_y_q[mem_addr] <= mem_py;
      pin_q[mem_addr]    <= mem_pin;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign rd_x = rd_x_q;
  assign rd_y = rd_y_q;

endmodule
